data_fifo: RTL and testbench

Elastic buffer that sits directly downstream of the free-running `data_t` producer interface. It captures one `data_t` word per cycle whenever `i_valid` is high and presents the words in order to a valid/ready consumer. The producer cannot be back-pressured, so words arriving while the buffer is full are dropped and latched in a sticky overflow flag. `data_t` is the shared packed struct `{ logic [7:0] data; }`.

---
 rtl/data_fifo.sv | 121 ++++++++++++
 tb/tb_data_fifo.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/data_fifo.sv
// Elastic FIFO behind a free-running, non-stallable data_t producer; overflowing words are dropped
// and flagged. Define DATA_FIFO_COUNT_EN to add the registered o_count occupancy port.

package data_fifo_pkg;
  typedef struct packed {
    logic [7:0] data;
  } data_t;
endpackage

module data_fifo
  import data_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_flush,
  input  logic  i_valid,
  input  data_t i_a,
  output logic  o_valid,
  input  logic  i_ready,
  output data_t o_a,
  output logic  o_overflow
`ifdef DATA_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] o_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  data_t         mem_q [DEPTH];
  data_t         mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;

  logic empty, full, push, pop, drop;

  // The extra pointer MSB separates the full case from the empty case when the indices match.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    pop   = !empty && i_ready;
    push  = i_valid && (!full || pop);
    drop  = i_valid && full && !pop;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (i_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[AW-1:0]] = i_a;
        wr_ptr_d                = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (drop) overflow_d = 1'b1;
    end
  end

  // NOTE: the storage array is reset too, so o_a reads as zero straight out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_valid    = !empty;
  assign o_a        = mem_q[rd_ptr_q[AW-1:0]];
  assign o_overflow = overflow_q;

`ifdef DATA_FIFO_COUNT_EN
  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] ptr_diff;

  always_comb begin
    count_d = count_q;
    if (i_flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + PW'(1);
        2'b01:   count_d = count_q - PW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) count_q <= '0;
    else          count_q <= count_d;
  end

  // The counter is a cheaper-to-read copy of the pointer difference; both must always agree.
  assign ptr_diff = wr_ptr_q - rd_ptr_q;
  always_ff @(posedge i_clk) begin
    if (i_rst_n) assert (count_q == ptr_diff);
  end

  assign o_count = count_q;
`endif

endmodule

// File: tb/tb_data_fifo.sv
// Self-checking bench for data_fifo: directed test-plan scenarios plus random traffic,
// all compared against a queue-based reference model.

module tb_data_fifo;
  import data_fifo_pkg::*;

  localparam int DEPTH = 4;

  logic  i_clk = 1'b0;
  logic  i_rst_n;
  logic  i_flush;
  logic  i_valid;
  data_t i_a;
  logic  o_valid;
  logic  i_ready;
  data_t o_a;
  logic  o_overflow;
`ifdef DATA_FIFO_COUNT_EN
  logic [$clog2(DEPTH):0] o_count;
`endif

  data_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .i_a        (i_a),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_a        (o_a),
    .o_overflow (o_overflow)
`ifdef DATA_FIFO_COUNT_EN
    ,
    .o_count    (o_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the queue holds the words in delivery order.
  logic [7:0] mq[$];
  bit         m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".o_valid"}, 32'(o_valid), 32'(mq.size() != 0));
    check({tag, ".o_overflow"}, 32'(o_overflow), 32'(m_ovf));
    if (mq.size() != 0) check({tag, ".o_a"}, 32'(o_a.data), 32'(mq[0]));
`ifdef DATA_FIFO_COUNT_EN
    check({tag, ".o_count"}, 32'(o_count), 32'(mq.size()));
`endif
  endtask

  // Called one time unit after a rising edge: drive inputs, check outputs, advance the model.
  task automatic step(input string tag, input bit fl, input bit v, input logic [7:0] a,
                      input bit rdy);
    bit m_pop, m_full;
    i_flush = fl;
    i_valid = v;
    i_a     = '{data: a};
    i_ready = rdy;
    #1;
    check_outputs(tag);
    if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      m_pop  = (mq.size() != 0) && rdy;
      m_full = (mq.size() == DEPTH);
      if (m_pop) void'(mq.pop_front());
      if (v) begin
        if (!m_full || m_pop) mq.push_back(a);
        else                  m_ovf = 1'b1;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_a     = '0;
    i_ready = 1'b0;
    m_ovf   = 1'b0;

    // Reset then idle
    repeat (3) begin
      @(posedge i_clk);
      #1;
      check("rst.o_valid", 32'(o_valid), 32'd0);
      check("rst.o_a", 32'(o_a.data), 32'h00);
      check("rst.o_overflow", 32'(o_overflow), 32'd0);
    end
    i_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("idle.o_a", 32'(o_a.data), 32'h00);
      step("idle", 0, 0, 8'h00, 0);
    end

    // In-order delivery
    step("ord.push", 0, 1, 8'h11, 0);
    step("ord.push", 0, 1, 8'h22, 0);
    step("ord.push", 0, 1, 8'h33, 0);
    for (int i = 0; i < 4; i++) step("ord.drain", 0, 0, 8'h00, 1);

    // Full with concurrent pop
    for (int i = 0; i < 4; i++) step("full.fill", 0, 1, 8'hA0 + 8'(i), 0);
    for (int i = 0; i < 4; i++) step("full.pushpop", 0, 1, 8'hB0 + 8'(i), 1);
    for (int i = 0; i < 5; i++) step("full.drain", 0, 0, 8'h00, 1);

    // Overflow
    for (int i = 0; i < 4; i++) step("ovf.fill", 0, 1, 8'h40 + 8'(i), 0);
    step("ovf.drop", 0, 1, 8'hFF, 0);
    check("ovf.flag", 32'(o_overflow), 32'd1);
    for (int i = 0; i < 5; i++) step("ovf.drain", 0, 0, 8'h00, 1);

    // Flush priority, overflow still set from the previous scenario
    for (int i = 0; i < 3; i++) step("fl.fill", 0, 1, 8'h70 + 8'(i), 0);
    step("fl.flush", 1, 1, 8'h5A, 1);
    check("fl.o_valid", 32'(o_valid), 32'd0);
    check("fl.o_overflow", 32'(o_overflow), 32'd0);
    for (int i = 0; i < 2; i++) step("fl.idle", 0, 0, 8'h00, 1);

    // Pointer wrap: 20 words, ready toggling
    for (int i = 0; i < 40; i++)
      step("wrap", 0, (i % 2) == 0, 8'h60 + 8'(i / 2), (i % 2) == 1);
    step("wrap.hold", 0, 1, 8'hC1, 0);
    step("wrap.hold", 0, 1, 8'hC2, 0);
    check("wrap.held", 32'(o_valid), 32'd1);

    // Asynchronous reset between edges
    #3;
    i_rst_n = 1'b0;
    #1;
    check("arst.o_valid", 32'(o_valid), 32'd0);
    check("arst.o_a", 32'(o_a.data), 32'h00);
    check("arst.o_overflow", 32'(o_overflow), 32'd0);
    mq.delete();
    m_ovf = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(31) == 0, $urandom_range(3) != 0,
           8'($urandom), $urandom_range(1) == 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
